l1_port_arbiter: RTL
====================

// Module: l1_port_arbiter
// PURPOSE
//  Two-requester arbiter sharing the single CPU-side request port of L1_cache.
//  Port 0 = instruction fetch, port 1 = load/store unit.
//  Latches the winning request and holds it stable toward the cache until the cache answers.
//  Routes the result back to the winner as a one-cycle ready pulse, with round-robin fairness.
//  Includes a sticky watchdog that flags a cache that never responds.
// PARAMETERS
//  ADDR_W       27    request address width (matches cpu_req_type.addr)
//  DATA_W       32    request/response data width
//  TIMEOUT_CYC  1023  BUSY cycles without cache_rsp_ready before timeout_err sets (>=2)
// PORTS
//  sys_clk         in   1       system clock, all logic on posedge
//  RST_N           in   1       asynchronous active-low reset
//  req0_addr       in   ADDR_W  port 0 address
//  req0_data       in   DATA_W  port 0 write data
//  req0_rw         in   1       port 0 rw, passed through unchanged
//  req0_valid      in   1       port 0 request; held with fields stable until rsp0_ready
//  rsp0_data       out  DATA_W  port 0 result data, valid while rsp0_ready=1
//  rsp0_ready      out  1       port 0 one-cycle completion pulse
//  req1_*/rsp1_*   --   --      identical set for port 1
//  cache_addr      out  ADDR_W  to L1_cache cpu_to_cache_request.addr
//  cache_data      out  DATA_W  to cpu_to_cache_request.data
//  cache_rw        out  1       to cpu_to_cache_request.rw
//  cache_valid     out  1       to cpu_to_cache_request.valid
//  cache_rsp_data  in   DATA_W  from cpu_res.data
//  cache_rsp_ready in   1       from cpu_res.ready
//  grant           out  1       port owning the current/last transaction
//  busy            out  1       1 in BUSY or RESP
//  timeout_err     out  1       sticky watchdog flag
// BEHAVIOUR
//  - Reset values: all outputs 0; state=IDLE; last_grant=1, so port 0 wins first; wd_cnt=0.
//  - All outputs are registered. There is no combinational path from any input to any output.
//  - FSM states IDLE, BUSY, RESP:
//    - IDLE, no valid: stay.
//      - Only one valid: grant that port.
//      - Both valid: grant the port != last_grant.
//      - On grant: latch addr/data/rw into the cache_* registers, set cache_valid=1, grant=winner,
//        last_grant=winner, wd_cnt=0, go to BUSY.
//      - Latency: req valid in cycle N -> cache_valid=1 in N+1.
//    - BUSY: cache_* held constant; requester input changes are ignored.
//      - On cache_rsp_ready: rspW_data<=cache_rsp_data, rspW_ready<=1, cache_valid<=0, go to RESP.
//      - Otherwise wd_cnt increments, saturating at TIMEOUT_CYC.
//    - RESP: rspW_ready=1 for exactly this one cycle, then 0; go to IDLE.
//      - Requests are not sampled in RESP, so the requester can advance its request on the pulse edge.
//  - Gap timing: cache_valid is low for exactly 2 cycles (RESP, then IDLE) between back-to-back
//    transactions.
//  - rspW_data holds its value after the pulse until the next response to the same port.
//    The other port's rsp_data is untouched.
//  - cache_rsp_ready while in IDLE or RESP: ignored, no rsp pulse. This covers stale or
//    post-reset responses.
//  - Requester drops valid while in BUSY (protocol violation): the transaction still completes
//    and the pulse is still issued.
//  - Watchdog: when wd_cnt reaches TIMEOUT_CYC in BUSY without ready, timeout_err<=1.
//    - timeout_err stays 1 until reset.
//    - The transaction is not aborted; a late cache_rsp_ready still completes it.
//    - wd_cnt width is $clog2(TIMEOUT_CYC+1).
//  - Reset asserted mid-transaction: outputs clear immediately (asynchronously), including
//    cache_valid and timeout_err.
//    - After release: IDLE, port 0 has priority.
// TESTING
//  T1 Single read:
//     - Stimulus: req0 addr=0x2AAAAAA rw=1 valid from c0; cache_rsp_ready with data 0x33333333 at c3.
//     - Required: c1 cache_valid=1 with same addr/rw; c4 rsp0_ready=1, rsp0_data=0x33333333,
//       cache_valid=0; c5 rsp0_ready=0; rsp1_ready=0 throughout.
//  T2 Fairness:
//     - Stimulus: both ports valid continuously from reset, 3 transactions each, cache answers
//       1 cycle after cache_valid.
//     - Required: grant sequence 0,1,0,1,0,1; cache_addr matches the granted port each time.
//  T3 Back-to-back single port:
//     - Stimulus: port 1 issues 4 requests with data 0xABCDEF00..0xABCDEF03.
//     - Required: 4 rsp1_ready pulses with matching data; cache_valid low exactly 2 cycles
//       between transactions.
//  T4 Watchdog:
//     - Stimulus: TIMEOUT_CYC=16, cache_rsp_ready never asserted.
//     - Required: timeout_err=1 16 cycles after cache_valid rises; cache_valid stays 1.
//     - Then assert cache_rsp_ready: the rsp pulse occurs and timeout_err remains 1.
//  T5 Reset mid-BUSY:
//     - Stimulus: RST_N low for 2 cycles while cache_valid=1.
//     - Required: all outputs 0 immediately; cache_rsp_ready pulsed during the following IDLE
//       gives no rsp pulse; with both ports then valid, port 0 is granted first.
//  T6 Stale ready:
//     - Stimulus: cache_rsp_ready pulsed while IDLE and while RESP.
//     - Required: no extra rsp0/rsp1 pulses; FSM sequence unchanged.

Source files
------------

// File: rtl/l1_port_arbiter.sv
// l1_port_arbiter: shares the single CPU-side request port of L1_cache between
// instruction fetch (port 0) and the load/store unit (port 1). The winning
// request is latched and held toward the cache until it answers. The answer is
// returned to the winner as a one-cycle ready pulse. Arbitration is round-robin.
// A sticky watchdog flags a cache that stays silent too long.
module l1_port_arbiter #(
  parameter int ADDR_W      = 27,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic              sys_clk,
  input  logic              RST_N,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req0_rw,
  input  logic              req0_valid,
  output logic [DATA_W-1:0] rsp0_data,
  output logic              rsp0_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              req1_rw,
  input  logic              req1_valid,
  output logic [DATA_W-1:0] rsp1_data,
  output logic              rsp1_ready,
  output logic [ADDR_W-1:0] cache_addr,
  output logic [DATA_W-1:0] cache_data,
  output logic              cache_rw,
  output logic              cache_valid,
  input  logic [DATA_W-1:0] cache_rsp_data,
  input  logic              cache_rsp_ready,
  output logic              grant,
  output logic              busy,
  output logic              timeout_err
);

  localparam int              WD_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYC);
  localparam logic [WD_W-1:0] WD_ONE = WD_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_r, state_s;
  logic              last_grant_r, last_grant_s;
  logic [WD_W-1:0]   wd_cnt_r, wd_cnt_s;
  logic [ADDR_W-1:0] cache_addr_s;
  logic [DATA_W-1:0] cache_data_s;
  logic              cache_rw_s;
  logic              cache_valid_s;
  logic              grant_s;
  logic              busy_s;
  logic              timeout_err_s;
  logic [DATA_W-1:0] rsp0_data_s, rsp1_data_s;
  logic              rsp0_ready_s, rsp1_ready_s;
  logic              take_s;
  logic              win_s;

  // Next-state and next-output computation; every register holds by default.
  always_comb begin
    state_s       = state_r;
    last_grant_s  = last_grant_r;
    wd_cnt_s      = wd_cnt_r;
    cache_addr_s  = cache_addr;
    cache_data_s  = cache_data;
    cache_rw_s    = cache_rw;
    cache_valid_s = cache_valid;
    grant_s       = grant;
    timeout_err_s = timeout_err;
    rsp0_data_s   = rsp0_data;
    rsp1_data_s   = rsp1_data;
    rsp0_ready_s  = 1'b0;
    rsp1_ready_s  = 1'b0;
    take_s        = 1'b0;
    win_s         = 1'b0;

    case (state_r)
      IDLE: begin
        // Round-robin: on a tie the port that did not win last time goes first.
        if (req0_valid && req1_valid) begin
          take_s = 1'b1;
          win_s  = ~last_grant_r;
        end else if (req0_valid) begin
          take_s = 1'b1;
          win_s  = 1'b0;
        end else if (req1_valid) begin
          take_s = 1'b1;
          win_s  = 1'b1;
        end else begin
          take_s = 1'b0;
          win_s  = 1'b0;
        end

        if (take_s) begin
          cache_addr_s  = win_s ? req1_addr : req0_addr;
          cache_data_s  = win_s ? req1_data : req0_data;
          cache_rw_s    = win_s ? req1_rw   : req0_rw;
          cache_valid_s = 1'b1;
          grant_s       = win_s;
          last_grant_s  = win_s;
          wd_cnt_s      = {WD_W{1'b0}};
          state_s       = BUSY;
        end else begin
          state_s = IDLE;
        end
      end

      BUSY: begin
        // Requester inputs are ignored here; only the cache answer matters.
        if (cache_rsp_ready) begin
          if (grant) begin
            rsp1_data_s  = cache_rsp_data;
            rsp1_ready_s = 1'b1;
          end else begin
            rsp0_data_s  = cache_rsp_data;
            rsp0_ready_s = 1'b1;
          end
          cache_valid_s = 1'b0;
          state_s       = RESP;
        end else begin
          if (wd_cnt_r != WD_MAX) begin
            wd_cnt_s = wd_cnt_r + WD_ONE;
          end else begin
            wd_cnt_s = wd_cnt_r;
          end
          // The transaction keeps waiting; the flag only reports the stall.
          if (wd_cnt_s == WD_MAX) begin
            timeout_err_s = 1'b1;
          end else begin
            timeout_err_s = timeout_err;
          end
          state_s = BUSY;
        end
      end

      RESP: begin
        // Pulse cycle: requests are not sampled so the requester can advance.
        state_s = IDLE;
      end

      default: begin
        state_s       = IDLE;
        cache_valid_s = 1'b0;
      end
    endcase

    busy_s = (state_s != IDLE);
  end

  // State, arbitration memory, watchdog and all registered outputs.
  always_ff @(posedge sys_clk or negedge RST_N) begin
    if (!RST_N) begin
      state_r      <= IDLE;
      last_grant_r <= 1'b1;
      wd_cnt_r     <= {WD_W{1'b0}};
      cache_addr   <= {ADDR_W{1'b0}};
      cache_data   <= {DATA_W{1'b0}};
      cache_rw     <= 1'b0;
      cache_valid  <= 1'b0;
      grant        <= 1'b0;
      busy         <= 1'b0;
      timeout_err  <= 1'b0;
      rsp0_data    <= {DATA_W{1'b0}};
      rsp1_data    <= {DATA_W{1'b0}};
      rsp0_ready   <= 1'b0;
      rsp1_ready   <= 1'b0;
    end else begin
      state_r      <= state_s;
      last_grant_r <= last_grant_s;
      wd_cnt_r     <= wd_cnt_s;
      cache_addr   <= cache_addr_s;
      cache_data   <= cache_data_s;
      cache_rw     <= cache_rw_s;
      cache_valid  <= cache_valid_s;
      grant        <= grant_s;
      busy         <= busy_s;
      timeout_err  <= timeout_err_s;
      rsp0_data    <= rsp0_data_s;
      rsp1_data    <= rsp1_data_s;
      rsp0_ready   <= rsp0_ready_s;
      rsp1_ready   <= rsp1_ready_s;
    end
  end

endmodule
